// File: rtl/result_broadcast_bus_pkg.sv
// Shared types and helpers for the result broadcast bus and its consumers.
package result_broadcast_bus_pkg;

  localparam int RBB_UNITS         = 4;
  localparam int RBB_OPERAND_WIDTH = 32;
  localparam int RBB_RS_ID_WIDTH   = 5;

  // One broadcast beat as seen by reservation stations and rename logic.
  typedef struct packed {
    logic                         valid;
    logic [RBB_RS_ID_WIDTH-1:0]   rs_id;
    logic [RBB_OPERAND_WIDTH-1:0] value;
  } result_bus_t;

  // Successor of a round-robin index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/result_broadcast_bus_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// scanning upward from the pointer, wrapping modulo N.
module result_broadcast_bus_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_any_grant
);

  // Priority scan starting at the pointer; the first valid request wins.
  always_comb begin
    int idx;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    idx         = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(i_ptr) + i) % N;
      if (!o_any_grant && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        o_grant_idx  = IW'(idx);
        o_any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_broadcast_bus.sv
// Result broadcast bus: one-entry buffer per execution unit, round-robin
// selection, and a registered one-cycle broadcast to all consumers.
module result_broadcast_bus
  import result_broadcast_bus_pkg::*;
#(
  parameter int UNITS         = RBB_UNITS,
  parameter int OPERAND_WIDTH = RBB_OPERAND_WIDTH,
  parameter int RS_ID_WIDTH   = RBB_RS_ID_WIDTH,
  localparam int IW           = (UNITS > 1) ? $clog2(UNITS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [UNITS-1:0]                    unit_valid,
  output logic [UNITS-1:0]                    unit_ready,
  input  logic [UNITS-1:0][RS_ID_WIDTH-1:0]   unit_rs_id,
  input  logic [UNITS-1:0][OPERAND_WIDTH-1:0] unit_value,
  output logic                                result_valid,
  output logic [RS_ID_WIDTH-1:0]              result_rs_id,
  output logic [OPERAND_WIDTH-1:0]            result_value,
  output logic [IW-1:0]                       result_unit
);

  logic [UNITS-1:0]                    r_buf_vld_p0;
  logic [UNITS-1:0][RS_ID_WIDTH-1:0]   r_buf_id_p0;
  logic [UNITS-1:0][OPERAND_WIDTH-1:0] r_buf_val_p0;
  logic [IW-1:0]                       r_rr_ptr;

  logic                                r_res_vld_p1;
  logic [RS_ID_WIDTH-1:0]              r_res_id_p1;
  logic [OPERAND_WIDTH-1:0]            r_res_val_p1;
  logic [IW-1:0]                       r_res_unit_p1;

  logic [UNITS-1:0]                    w_grant;
  logic [IW-1:0]                       w_grant_idx;
  logic                                w_any_grant;
  logic [UNITS-1:0]                    w_accept;
  logic [IW-1:0]                       w_ptr_next;

  result_broadcast_bus_rr_arbiter #(
    .N  (UNITS),
    .IW (IW)
  ) u_arb (
    .i_req       (r_buf_vld_p0),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  // A buffer can take a new result when empty or when it drains this cycle,
  // so a lone streaming unit never sees a bubble.
  assign unit_ready = ~r_buf_vld_p0 | w_grant;
  assign w_accept   = unit_valid & unit_ready;
  assign w_ptr_next = IW'(rr_next(int'(w_grant_idx), UNITS));

  // Buffer occupancy: cleared by a grant, set by an accept (accept wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_vld_p0 <= '0;
    end else begin
      r_buf_vld_p0 <= (r_buf_vld_p0 & ~w_grant) | w_accept;
    end
  end

  // Buffer payload: loaded on accept, qualified by the occupancy bit.
  always_ff @(posedge clk) begin
    for (int u = 0; u < UNITS; u++) begin
      if (w_accept[u]) begin
        r_buf_id_p0[u]  <= unit_rs_id[u];
        r_buf_val_p0[u] <= unit_value[u];
      end
    end
  end

  // Round-robin pointer moves just past the unit that won.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_any_grant) begin
      r_rr_ptr <= w_ptr_next;
    end
  end

  // ---- stage p0 -> p1: registered broadcast ----
  // Broadcast valid pulses per grant; payload holds when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_vld_p1  <= 1'b0;
      r_res_id_p1   <= '0;
      r_res_val_p1  <= '0;
      r_res_unit_p1 <= '0;
    end else begin
      r_res_vld_p1 <= w_any_grant;
      if (w_any_grant) begin
        r_res_id_p1   <= r_buf_id_p0[w_grant_idx];
        r_res_val_p1  <= r_buf_val_p0[w_grant_idx];
        r_res_unit_p1 <= w_grant_idx;
      end
    end
  end

  assign result_valid = r_res_vld_p1;
  assign result_rs_id = r_res_id_p1;
  assign result_value = r_res_val_p1;
  assign result_unit  = r_res_unit_p1;

endmodule

// File: tb/tb_result_broadcast_bus.sv
// Directed testbench for result_broadcast_bus (UNITS=4, 32-bit values, 5-bit tags).
module tb_result_broadcast_bus;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        unit_valid;
  logic [3:0]        unit_ready;
  logic [3:0][4:0]   unit_rs_id;
  logic [3:0][31:0]  unit_value;
  logic              result_valid;
  logic [4:0]        result_rs_id;
  logic [31:0]       result_value;
  logic [1:0]        result_unit;

  int checks   = 0;
  int failures = 0;

  logic [39:0] got_bus;
  logic [39:0] exp_bus;

  always #5 clk = ~clk;

  result_broadcast_bus #(
    .UNITS         (4),
    .OPERAND_WIDTH (32),
    .RS_ID_WIDTH   (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .unit_valid   (unit_valid),
    .unit_ready   (unit_ready),
    .unit_rs_id   (unit_rs_id),
    .unit_value   (unit_value),
    .result_valid (result_valid),
    .result_rs_id (result_rs_id),
    .result_value (result_value),
    .result_unit  (result_unit)
  );

  assign got_bus = {result_valid, result_unit, result_rs_id, result_value};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    unit_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    unit_valid = '0;
    unit_rs_id = '0;
    unit_value = '0;
    step();
    checks++;
    if (got_bus !== 40'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=%h", got_bus, 40'h0);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (got_bus !== 40'h0) begin
        failures++;
        $display("FAIL idle_bus[%0d] got=%h exp=%h", k, got_bus, 40'h0);
      end
      checks++;
      if (unit_ready !== 4'hF) begin
        failures++;
        $display("FAIL idle_ready[%0d] got=%b exp=%b", k, unit_ready, 4'hF);
      end
    end
  endtask

  task automatic test_single();
    unit_valid[2] = 1'b1;
    unit_rs_id[2] = 5'd5;
    unit_value[2] = 32'hDEADBEEF;
    step();
    unit_valid = '0;
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early got=%b exp=0", result_valid);
    end
    step();
    exp_bus = {1'b1, 2'd2, 5'd5, 32'hDEADBEEF};
    checks++;
    if (got_bus !== exp_bus) begin
      failures++;
      $display("FAIL single_bcast got=%h exp=%h", got_bus, exp_bus);
    end
    step();
    exp_bus = {1'b0, 2'd2, 5'd5, 32'hDEADBEEF};
    checks++;
    if (got_bus !== exp_bus) begin
      failures++;
      $display("FAIL single_hold got=%h exp=%h", got_bus, exp_bus);
    end
    step();
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_dup got=%b exp=0", result_valid);
    end
  endtask

  task automatic test_all_four();
    logic [3:0] rdy_exp [4];
    rdy_exp = '{4'b0011, 4'b0111, 4'b1111, 4'b1111};
    do_reset();
    for (int u = 0; u < 4; u++) begin
      unit_rs_id[u] = 5'(u + 1);
      unit_value[u] = 32'hA0000000 + 32'(u);
    end
    unit_valid = 4'hF;
    step();
    unit_valid = '0;
    checks++;
    if (unit_ready !== 4'b0001) begin
      failures++;
      $display("FAIL all4_ready_init got=%b exp=%b", unit_ready, 4'b0001);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      exp_bus = {1'b1, 2'(k), 5'(k + 1), 32'hA0000000 + 32'(k)};
      checks++;
      if (got_bus !== exp_bus) begin
        failures++;
        $display("FAIL all4_bcast[%0d] got=%h exp=%h", k, got_bus, exp_bus);
      end
      checks++;
      if (unit_ready !== rdy_exp[k]) begin
        failures++;
        $display("FAIL all4_ready[%0d] got=%b exp=%b", k, unit_ready, rdy_exp[k]);
      end
    end
    step();
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL all4_end got=%b exp=0", result_valid);
    end
    // Pointer must be back at 0: unit 0 beats unit 3.
    unit_rs_id[0] = 5'd20;
    unit_value[0] = 32'h00000020;
    unit_rs_id[3] = 5'd23;
    unit_value[3] = 32'h00000023;
    unit_valid    = 4'b1001;
    step();
    unit_valid = '0;
    step();
    exp_bus = {1'b1, 2'd0, 5'd20, 32'h00000020};
    checks++;
    if (got_bus !== exp_bus) begin
      failures++;
      $display("FAIL ptr_wrap_first got=%h exp=%h", got_bus, exp_bus);
    end
    step();
    exp_bus = {1'b1, 2'd3, 5'd23, 32'h00000023};
    checks++;
    if (got_bus !== exp_bus) begin
      failures++;
      $display("FAIL ptr_wrap_second got=%h exp=%h", got_bus, exp_bus);
    end
  endtask

  task automatic test_stream_single();
    do_reset();
    unit_valid[1] = 1'b1;
    unit_rs_id[1] = 5'd8;
    unit_value[1] = 32'h01010101 * 32'd8;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k >= 1) begin
        exp_bus = {1'b1, 2'd1, 5'(8 + k - 1), 32'h01010101 * 32'(8 + k - 1)};
        checks++;
        if (got_bus !== exp_bus) begin
          failures++;
          $display("FAIL stream1_bcast[%0d] got=%h exp=%h", k, got_bus, exp_bus);
        end
      end
      checks++;
      if (unit_ready[1] !== 1'b1) begin
        failures++;
        $display("FAIL stream1_ready[%0d] got=%b exp=1", k, unit_ready[1]);
      end
      unit_rs_id[1] = 5'(8 + k + 1);
      unit_value[1] = 32'h01010101 * 32'(8 + k + 1);
    end
    unit_valid = '0;
    step();
    exp_bus = {1'b1, 2'd1, 5'd15, 32'h01010101 * 32'd15};
    checks++;
    if (got_bus !== exp_bus) begin
      failures++;
      $display("FAIL stream1_last got=%h exp=%h", got_bus, exp_bus);
    end
    step();
    checks++;
    if (result_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream1_end got=%b exp=0", result_valid);
    end
  endtask

  task automatic test_stream_two();
    int  id0;
    int  id3;
    logic acc0;
    logic acc3;
    do_reset();
    id0 = 16;
    id3 = 24;
    unit_rs_id[0] = 5'(id0);
    unit_value[0] = 32'hC0000000 | 32'(id0);
    unit_rs_id[3] = 5'(id3);
    unit_value[3] = 32'hC0000000 | 32'(id3);
    unit_valid    = 4'b1001;
    acc0 = unit_ready[0];
    acc3 = unit_ready[3];
    for (int j = 0; j < 13; j++) begin
      step();
      if (j >= 1 && j <= 11) begin
        if (j % 2 == 1)
          exp_bus = {1'b1, 2'd0, 5'(16 + (j - 1) / 2), 32'hC0000000 | 32'(16 + (j - 1) / 2)};
        else
          exp_bus = {1'b1, 2'd3, 5'(24 + j / 2 - 1), 32'hC0000000 | 32'(24 + j / 2 - 1)};
        checks++;
        if (got_bus !== exp_bus) begin
          failures++;
          $display("FAIL stream2_bcast[%0d] got=%h exp=%h", j, got_bus, exp_bus);
        end
      end
      if (j == 12) begin
        checks++;
        if (result_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream2_end got=%b exp=0", result_valid);
        end
      end
      if (unit_valid[0] && acc0) id0++;
      if (unit_valid[3] && acc3) id3++;
      unit_rs_id[0] = 5'(id0);
      unit_value[0] = 32'hC0000000 | 32'(id0);
      unit_rs_id[3] = 5'(id3);
      unit_value[3] = 32'hC0000000 | 32'(id3);
      if (j == 9) unit_valid = '0;
      acc0 = unit_ready[0];
      acc3 = unit_ready[3];
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int u = 0; u < 4; u++) begin
      unit_rs_id[u] = 5'(u + 1);
      unit_value[u] = 32'hB0000000 + 32'(u);
    end
    unit_valid = 4'hF;
    step();
    unit_valid = '0;
    step();
    checks++;
    if (result_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre got=%b exp=1", result_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (got_bus !== 40'h0) begin
      failures++;
      $display("FAIL arst_immediate got=%h exp=%h", got_bus, 40'h0);
    end
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (result_valid !== 1'b0) begin
        failures++;
        $display("FAIL arst_after[%0d] got=%b exp=0", k, result_valid);
      end
    end
    checks++;
    if (unit_ready !== 4'hF) begin
      failures++;
      $display("FAIL arst_ready got=%b exp=%b", unit_ready, 4'hF);
    end
  endtask

  task automatic test_tag_zero();
    unit_rs_id[1] = 5'd0;
    unit_value[1] = 32'hFFFFFFFF;
    unit_valid    = 4'b0010;
    step();
    unit_valid = '0;
    step();
    exp_bus = {1'b1, 2'd1, 5'd0, 32'hFFFFFFFF};
    checks++;
    if (got_bus !== exp_bus) begin
      failures++;
      $display("FAIL tag_zero got=%h exp=%h", got_bus, exp_bus);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_stream_single();
    test_stream_two();
    test_async_reset();
    test_tag_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
